sa_rd_stream_buf: RTL and testbench

Elastic buffer between the AXI read DMA and the systolic array engine input. The read DMA produces a data/valid stream with no backpressure; the engine consumes a ready/valid stream.
- Absorbs read bursts into a first-word-fall-through (FWFT) FIFO.
- Counts the words of one transfer and marks the final beat with o_tlast.
- Reports FIFO overflow and signals completion once the engine has consumed the whole transfer.

---
 rtl/sa_stream_pkg.sv | 16 +
 rtl/sa_sync_fifo.sv | 66 ++++++
 rtl/sa_rd_stream_buf.sv | 143 ++++++++++++++
 tb/tb_sa_rd_stream_buf.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_stream_pkg.sv
// Shared types and defaults for the read-stream path between the read DMA,
// the elastic buffer and the systolic array engine.
package sa_stream_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_W      = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } rdbuf_state_t;

endpackage

// File: rtl/sa_sync_fifo.sv
// Generic first-word-fall-through FIFO. The head word is always visible on
// dout; a push in cycle N is visible the following cycle. flush empties the
// FIFO by resetting pointers and level. A push while full is only honoured
// when a pop happens in the same cycle.
module sa_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         cnt;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign level   = cnt;

    // Storage array: written on every accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/sa_rd_stream_buf.sv
// Elastic buffer between the read DMA (data/valid, no backpressure) and the
// systolic array engine (ready/valid). Counts one transfer, flags its last
// beat, reports overflow and pulses done once the engine has taken it all.
//
// Engine handshake: a beat transfers on any rising clk edge where o_tvalid
// and i_tready are both high; while o_tvalid is high and i_tready is low,
// o_tdata and o_tlast hold steady. o_tvalid does not depend on i_tready.
module sa_rd_stream_buf
    import sa_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int AF_MARGIN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [CNT_W-1:0]        i_num_trans,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_data_vld,
    output logic [DATA_WIDTH-1:0]   o_tdata,
    output logic                    o_tvalid,
    input  logic                    i_tready,
    output logic                    o_tlast,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_almost_full,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_overflow
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    rdbuf_state_t      state;
    logic [CNT_W-1:0]  num_trans;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic              overflow;
    logic              fifo_empty;
    logic              fifo_full;
    logic [LW-1:0]     level;
    logic              stream_on;
    logic              push;
    logic              pop;
    logic              flush;
    logic              last_out;
    logic              last_in;

    // The stream is only presented while the transfer is live; after an
    // overflow the contents are discarded rather than delivered with a hole.
    assign stream_on = (state == FILL) || (state == DRAIN);
    assign o_tvalid  = stream_on && !fifo_empty;
    assign pop       = o_tvalid && i_tready;
    assign push      = (state == FILL) && i_data_vld && (!fifo_full || pop);
    assign flush     = (state == FLUSH);
    assign last_out  = (out_cnt == num_trans - CNT_ONE);
    assign last_in   = (in_cnt + CNT_ONE == num_trans);

    assign o_tlast       = o_tvalid && last_out;
    assign o_level       = level;
    assign o_almost_full = (level >= LW'(DEPTH - AF_MARGIN));
    assign o_busy        = (state != IDLE);
    assign o_done        = (state == DONE);
    assign o_overflow    = overflow;

    sa_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (i_data),
        .dout  (o_tdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    // Transfer FSM with word counters and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            num_trans <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pop) begin
                out_cnt <= out_cnt + CNT_ONE;
            end
            case (state)
                IDLE: begin
                    if (i_start) begin
                        num_trans <= i_num_trans;
                        in_cnt    <= '0;
                        out_cnt   <= '0;
                        overflow  <= 1'b0;
                        state     <= (i_num_trans == '0) ? DONE : FILL;
                    end
                end
                FILL: begin
                    if (i_data_vld) begin
                        in_cnt <= in_cnt + CNT_ONE;
                        if (!push) begin
                            overflow <= 1'b1;
                            state    <= FLUSH;
                        end else if (last_in) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && last_out) begin
                        state <= DONE;
                    end
                end
                FLUSH: begin
                    // Swallow the rest of the burst so the DMA can finish.
                    if (in_cnt == num_trans) begin
                        state <= DONE;
                    end else if (i_data_vld) begin
                        in_cnt <= in_cnt + CNT_ONE;
                        if (last_in) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_rd_stream_buf.sv
// Directed bench for sa_rd_stream_buf (DEPTH=16, CNT_W=8, DATA_WIDTH=32).
// Inputs change and outputs are sampled just after each falling edge.
module tb_sa_rd_stream_buf;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int LW = 5;

    logic          clk;
    logic          rst;
    logic          i_start;
    logic [CW-1:0] i_num_trans;
    logic [DW-1:0] i_data;
    logic          i_data_vld;
    logic [DW-1:0] o_tdata;
    logic          o_tvalid;
    logic          i_tready;
    logic          o_tlast;
    logic [LW-1:0] o_level;
    logic          o_almost_full;
    logic          o_busy;
    logic          o_done;
    logic          o_overflow;

    int n_checks;
    int n_fail;

    sa_rd_stream_buf #(
        .DATA_WIDTH (DW),
        .DEPTH      (16),
        .CNT_W      (CW),
        .AF_MARGIN  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_num_trans   (i_num_trans),
        .i_data        (i_data),
        .i_data_vld    (i_data_vld),
        .o_tdata       (o_tdata),
        .o_tvalid      (o_tvalid),
        .i_tready      (i_tready),
        .o_tlast       (o_tlast),
        .o_level       (o_level),
        .o_almost_full (o_almost_full),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_overflow    (o_overflow)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({o_tvalid, o_tlast, o_almost_full, o_busy, o_done, o_overflow} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {o_tvalid, o_tlast, o_almost_full, o_busy, o_done, o_overflow});
        end
        n_checks++;
        if (o_level !== LW'(0)) begin
            n_fail++;
            $display("FAIL reset_level: got %0d expected 0", o_level);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] exp_d;
        int pops, done_seen, last_pop, done_cyc;
        pops = 0; done_seen = 0; last_pop = -10; done_cyc = -1;
        i_start = 1'b1; i_num_trans = 8'd8; i_tready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (o_done) begin done_seen++; done_cyc = cyc; end
            if (o_tvalid && i_tready) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_checks++;
                if (o_tdata !== exp_d) begin
                    n_fail++;
                    $display("FAIL basic_data: beat %0d got %h expected %h", pops, o_tdata, exp_d);
                end
                n_checks++;
                if (o_tlast !== (pops == 7)) begin
                    n_fail++;
                    $display("FAIL basic_tlast: beat %0d got %b expected %b", pops, o_tlast, pops == 7);
                end
                pops++; last_pop = cyc;
            end
            if (cyc < 8) begin
                i_data_vld = 1'b1; i_data = DW'(cyc); exp_q.push_back(DW'(cyc));
            end else begin
                i_data_vld = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++;
        if (pops !== 8) begin n_fail++; $display("FAIL basic_pops: got %0d expected 8", pops); end
        n_checks++;
        if (done_seen !== 1 || done_cyc !== last_pop + 1) begin
            n_fail++;
            $display("FAIL basic_done: got %0d pulses at cycle %0d expected 1 at cycle %0d",
                     done_seen, done_cyc, last_pop + 1);
        end
        n_checks++;
        if (o_overflow !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got ovf=%b busy=%b expected 0 0", o_overflow, o_busy);
        end
    endtask

    task automatic test_fill_level;
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] exp_d;
        int pops, done_seen, last_pop, done_cyc;
        pops = 0; done_seen = 0; last_pop = -10; done_cyc = -1;
        i_start = 1'b1; i_num_trans = 8'd16; i_tready = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            n_checks++;
            if (o_level !== LW'(cyc) || o_almost_full !== (cyc >= 12)) begin
                n_fail++;
                $display("FAIL fill_level: got level=%0d af=%b expected level=%0d af=%b",
                         o_level, o_almost_full, cyc, cyc >= 12);
            end
            i_data_vld = 1'b1; i_data = 32'hA5A5_0000 + DW'(cyc);
            exp_q.push_back(32'hA5A5_0000 + DW'(cyc));
            @(negedge clk);
        end
        i_data_vld = 1'b0;
        n_checks++;
        if (o_level !== LW'(16) || o_almost_full !== 1'b1 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got level=%0d af=%b ovf=%b expected 16 1 0",
                     o_level, o_almost_full, o_overflow);
        end
        i_tready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (o_done) begin done_seen++; done_cyc = cyc; end
            if (o_tvalid) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_checks++;
                if (o_tdata !== exp_d || o_tlast !== (pops == 15)) begin
                    n_fail++;
                    $display("FAIL fill_drain: beat %0d got %h/%b expected %h/%b",
                             pops, o_tdata, o_tlast, exp_d, pops == 15);
                end
                pops++; last_pop = cyc;
            end
            @(negedge clk);
        end
        n_checks++;
        if (pops !== 16 || done_seen !== 1 || done_cyc !== last_pop + 1) begin
            n_fail++;
            $display("FAIL fill_done: got pops=%0d done=%0d at %0d expected 16 1 at %0d",
                     pops, done_seen, done_cyc, last_pop + 1);
        end
    endtask

    task automatic test_full_pop_push;
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] exp_d;
        int pops, done_seen;
        pops = 0; done_seen = 0;
        i_start = 1'b1; i_num_trans = 8'd18; i_tready = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            // the last two words arrive while the FIFO is full and popping
            i_tready = (cyc >= 16);
            if (cyc >= 16) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_checks++;
                if (o_tvalid !== 1'b1 || o_tdata !== exp_d || o_level !== LW'(16)) begin
                    n_fail++;
                    $display("FAIL fpp_head: got v=%b d=%h lvl=%0d expected 1 %h 16",
                             o_tvalid, o_tdata, o_level, exp_d);
                end
                pops++;
            end
            i_data_vld = 1'b1; i_data = 32'h0BAD_0000 + DW'(cyc);
            exp_q.push_back(32'h0BAD_0000 + DW'(cyc));
            @(negedge clk);
        end
        i_data_vld = 1'b0;
        n_checks++;
        if (o_level !== LW'(16) || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fpp_level: got level=%0d ovf=%b expected 16 0", o_level, o_overflow);
        end
        i_tready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (o_done) done_seen++;
            if (o_tvalid) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_checks++;
                if (o_tdata !== exp_d || o_tlast !== (pops == 17)) begin
                    n_fail++;
                    $display("FAIL fpp_drain: beat %0d got %h/%b expected %h/%b",
                             pops, o_tdata, o_tlast, exp_d, pops == 17);
                end
                pops++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (pops !== 18 || done_seen !== 1 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fpp_done: got pops=%0d done=%0d ovf=%b expected 18 1 0",
                     pops, done_seen, o_overflow);
        end
    endtask

    task automatic test_overflow;
        i_start = 1'b1; i_num_trans = 8'd20; i_tready = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 16) begin
                n_checks++;
                if (o_overflow !== 1'b0 || o_tvalid !== 1'b1 || o_level !== LW'(16)) begin
                    n_fail++;
                    $display("FAIL ovf_before: got ovf=%b v=%b lvl=%0d expected 0 1 16",
                             o_overflow, o_tvalid, o_level);
                end
            end
            if (k >= 17) begin
                n_checks++;
                if (o_overflow !== 1'b1 || o_tvalid !== 1'b0 || o_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_after: word %0d got ovf=%b v=%b done=%b expected 1 0 0",
                             k, o_overflow, o_tvalid, o_done);
                end
            end
            i_data_vld = 1'b1; i_data = DW'(k);
            @(negedge clk);
        end
        i_data_vld = 1'b0;
        n_checks++;
        if (o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_done: got %b expected 1", o_done);
        end
        @(negedge clk);
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_overflow !== 1'b1 || o_level !== LW'(0)) begin
            n_fail++;
            $display("FAIL ovf_idle: got done=%b busy=%b ovf=%b lvl=%0d expected 0 0 1 0",
                     o_done, o_busy, o_overflow, o_level);
        end
        i_start = 1'b1; i_num_trans = 8'd1;
        @(negedge clk);
        i_start = 1'b0;
        n_checks++;
        if (o_overflow !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_clear: got ovf=%b busy=%b expected 0 1", o_overflow, o_busy);
        end
        i_data_vld = 1'b1; i_data = 32'hCAFE_F00D; i_tready = 1'b1;
        @(negedge clk);
        i_data_vld = 1'b0;
        n_checks++;
        if (o_tvalid !== 1'b1 || o_tlast !== 1'b1 || o_tdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL ovf_single: got v=%b l=%b d=%h expected 1 1 cafef00d",
                     o_tvalid, o_tlast, o_tdata);
        end
        @(negedge clk);
        n_checks++;
        if (o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_single_done: got %b expected 1", o_done);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_and_restart;
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] exp_d;
        int pops, done_seen;
        pops = 0; done_seen = 0;
        i_start = 1'b1; i_num_trans = 8'd0; i_tready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        n_checks++;
        if (o_done !== 1'b1 || o_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: got done=%b v=%b expected 1 0", o_done, o_tvalid);
        end
        @(negedge clk);
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle: got done=%b busy=%b v=%b expected 0 0 0",
                     o_done, o_busy, o_tvalid);
        end
        i_start = 1'b1; i_num_trans = 8'd3;
        @(negedge clk);
        for (int cyc = 0; cyc < 12; cyc++) begin
            // a second start with a different length lands while filling
            i_start = (cyc == 0);
            i_num_trans = 8'd5;
            if (o_done) done_seen++;
            if (o_tvalid) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_checks++;
                if (o_tdata !== exp_d || o_tlast !== (pops == 2)) begin
                    n_fail++;
                    $display("FAIL restart_beat: beat %0d got %h/%b expected %h/%b",
                             pops, o_tdata, o_tlast, exp_d, pops == 2);
                end
                pops++;
            end
            if (cyc < 3) begin
                i_data_vld = 1'b1; i_data = 32'h1234_0000 + DW'(cyc);
                exp_q.push_back(32'h1234_0000 + DW'(cyc));
            end else begin
                i_data_vld = 1'b0;
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        n_checks++;
        if (pops !== 3 || done_seen !== 1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_done: got pops=%0d done=%0d busy=%b expected 3 1 0",
                     pops, done_seen, o_busy);
        end
    endtask

    task automatic test_reset_mid;
        int done_seen;
        done_seen = 0;
        i_start = 1'b1; i_num_trans = 8'd10; i_tready = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_data_vld = 1'b1; i_data = DW'(k + 100);
            @(negedge clk);
        end
        i_data_vld = 1'b0;
        n_checks++;
        if (o_level !== LW'(5) || o_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got lvl=%0d v=%b expected 5 1", o_level, o_tvalid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (o_level !== LW'(0) || o_tvalid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_post: got lvl=%0d v=%b busy=%b done=%b expected 0 0 0 0",
                     o_level, o_tvalid, o_busy, o_done);
        end
        for (int k = 0; k < 5; k++) begin
            if (o_done || o_busy) done_seen++;
            @(negedge clk);
        end
        n_checks++;
        if (done_seen !== 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got %0d busy/done cycles expected 0", done_seen);
        end
    endtask

    // sequence of scenarios and final report
    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; i_start = 1'b0; i_num_trans = '0; i_data = '0;
        i_data_vld = 1'b0; i_tready = 1'b0;
        test_reset;
        test_basic;
        test_fill_level;
        test_full_pop_push;
        test_overflow;
        test_zero_and_restart;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
